risc_toy_fetch: RTL and testbench

RISC_TOY_FETCH -- requirements
Module: risc_toy_fetch

---
 rtl/risc_toy_fetch.sv | 101 ++++++++++
 tb/tb_risc_toy_fetch.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/risc_toy_fetch.sv
// Instruction fetch unit: issues one-word requests to a fixed-latency memory and
// buffers returned words in a small prefetch queue feeding decode.
module risc_toy_fetch #(
    parameter int unsigned    AW     = 30,
    parameter int unsigned    DEPTH  = 4,
    parameter logic [AW-1:0]  RST_PC = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    output logic                         IREQ,
    output logic [AW-1:0]                IADDR,
    input  logic [31:0]                  INSTR,
    input  logic                         REDIR_EN,
    input  logic [AW-1:0]                REDIR_PC,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [31:0]                  OUT_INSTR,
    output logic [AW-1:0]                OUT_PC,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic [AW-1:0] fpc_q, fpc_d;
    logic          inflight_q;
    logic [AW-1:0] req_pc_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, wr_q;
    logic [31:0]   ins_mem_q [DEPTH];
    logic [AW-1:0] pc_mem_q  [DEPTH];

    logic          pop;
    logic          push;
    logic [OW-1:0] occ;

    // A redirect flushes everything, so neither a pop nor the returning word counts.
    assign pop  = (count_q != '0) && OUT_READY && !REDIR_EN;
    assign push = inflight_q && !REDIR_EN;

    // Occupancy the queue could reach once the outstanding word lands.
    assign occ  = OW'(count_q) + OW'(inflight_q) - OW'(pop);
    assign IREQ = !RST && !REDIR_EN && (occ < OW'(DEPTH));

    assign IADDR     = fpc_q;
    assign OUT_VALID = (count_q != '0);
    assign OUT_INSTR = ins_mem_q[rd_q];
    assign OUT_PC    = pc_mem_q[rd_q];
    assign COUNT     = count_q;

    always_comb begin
        fpc_d   = fpc_q;
        count_d = count_q;
        if (REDIR_EN) begin
            fpc_d   = REDIR_PC;
            count_d = '0;
        end else begin
            if (IREQ) begin
                fpc_d = fpc_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc_q      <= RST_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ins_mem_q[i] <= '0;
                pc_mem_q[i]  <= '0;
            end
        end else begin
            fpc_q      <= fpc_d;
            count_q    <= count_d;
            inflight_q <= IREQ;
            if (IREQ) begin
                req_pc_q <= fpc_q;
            end
            if (REDIR_EN) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (push) begin
                    ins_mem_q[wr_q] <= INSTR;
                    pc_mem_q[wr_q]  <= req_pc_q;
                    wr_q            <= wr_q + 1'b1;
                end
                if (pop) begin
                    rd_q <= rd_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Self-checking bench for risc_toy_fetch: directed scenarios followed by random
// back-pressure, redirects and resets, all scored against a queue-based model.
module tb_risc_toy_fetch;

    localparam int unsigned   AW     = 30;
    localparam int unsigned   DEPTH  = 4;
    localparam int unsigned   CW     = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] RST_PC = '0;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [31:0]   INSTR;
    logic          REDIR_EN;
    logic [AW-1:0] REDIR_PC;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [31:0]   OUT_INSTR;
    logic [AW-1:0] OUT_PC;
    logic [CW-1:0] COUNT;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   ins;
    } ent_t;

    ent_t          q[$];
    logic [AW-1:0] mpc;
    logic [AW-1:0] pend_pc;
    bit            infl;
    int            total = 0;
    int            bad   = 0;

    always #5 CLK = ~CLK;

    risc_toy_fetch #(
        .AW     (AW),
        .DEPTH  (DEPTH),
        .RST_PC (RST_PC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IREQ      (IREQ),
        .IADDR     (IADDR),
        .INSTR     (INSTR),
        .REDIR_EN  (REDIR_EN),
        .REDIR_PC  (REDIR_PC),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_INSTR (OUT_INSTR),
        .OUT_PC    (OUT_PC),
        .COUNT     (COUNT)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {a, 2'b00} ^ 32'hC3A5_0F1E;
    endfunction

    // Memory: one-cycle read latency, garbage on cycles without a request.
    always @(posedge CLK) begin
        INSTR <= IREQ ? mem_word(IADDR) : $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input bit rst, input bit redir, input logic [AW-1:0] rpc, input bit rdy);
        bit pop;
        bit ireq;
        int occ;
        RST       = rst;
        REDIR_EN  = redir;
        REDIR_PC  = rpc;
        OUT_READY = rdy;
        #1;
        pop  = (q.size() > 0) && rdy && !redir && !rst;
        occ  = q.size() + int'(infl) - int'(pop);
        ireq = !rst && !redir && (occ < int'(DEPTH));
        chk("ireq", 64'(IREQ), 64'(ireq));
        chk("iaddr", 64'(IADDR), 64'(mpc));
        chk("count", 64'(COUNT), 64'(q.size()));
        chk("count_bound", 64'(COUNT <= CW'(DEPTH)), 64'd1);
        chk("valid", 64'(OUT_VALID), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_pc", 64'(OUT_PC), 64'(q[0].pc));
            chk("out_instr", 64'(OUT_INSTR), 64'(q[0].ins));
        end
        @(posedge CLK);
        if (rst || redir) begin
            q.delete();
            infl = 1'b0;
            mpc  = rst ? RST_PC : rpc;
        end else begin
            if (pop) void'(q.pop_front());
            if (infl) q.push_back(ent_t'{pend_pc, mem_word(pend_pc)});
            if (ireq) begin
                pend_pc = mpc;
                mpc     = mpc + 1'b1;
            end
            infl = ireq;
        end
        #1;
    endtask

    initial begin
        int r;
        RST       = 1'b1;
        REDIR_EN  = 1'b0;
        REDIR_PC  = '0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        q.delete();
        mpc     = RST_PC;
        pend_pc = '0;
        infl    = 1'b0;

        // Reset state.
        repeat (2) cyc(1, 0, '0, 0);
        chk("rst_out_pc", 64'(OUT_PC), 64'd0);
        chk("rst_out_instr", 64'(OUT_INSTR), 64'd0);

        // Stream from reset with decode always ready.
        repeat (10) cyc(0, 0, '0, 1);

        // Back-pressure: queue fills, requests stop, then resume.
        repeat (8) cyc(0, 0, '0, 0);
        chk("full_count", 64'(COUNT), 64'(DEPTH));
        repeat (6) cyc(0, 0, '0, 1);

        // Redirect with three entries queued.
        for (int i = 0; i < 20 && q.size() != 3; i++) cyc(0, 0, '0, 0);
        chk("reach3", 64'(COUNT), 64'd3);
        cyc(0, 1, AW'(32'h100), 1);
        repeat (5) cyc(0, 0, '0, 0);
        chk("redir_head", 64'(OUT_PC), 64'h100);
        repeat (4) cyc(0, 0, '0, 1);

        // Fetch pointer wrap from all-ones to zero.
        cyc(0, 1, {AW{1'b1}} - 1'b1, 1);
        repeat (8) cyc(0, 0, '0, 1);

        // One-cycle reset mid-stream with two entries queued.
        for (int i = 0; i < 20 && q.size() != 2; i++) cyc(0, 0, '0, 0);
        chk("reach2", 64'(COUNT), 64'd2);
        cyc(1, 0, '0, 1);
        chk("mid_rst_count", 64'(COUNT), 64'd0);
        repeat (6) cyc(0, 0, '0, 1);

        // Random back-pressure with occasional redirects and resets.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            cyc(r == 0, (r >= 1) && (r <= 3), AW'($urandom),
                (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
